// File: rtl/multicycle_control.sv
// Multicycle MIPS main control: a Moore FSM that drives datapath selects and enables.
// Memory states wait on mem_ready_i; a bounded wait counter flags timeouts on err_o.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] op_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_en_o,
  output logic       iord_o,
  output logic       memread_o,
  output logic       memwrite_o,
  output logic       irwrite_o,
  output logic       regdst_o,
  output logic       memtoreg_o,
  output logic       regwrite_o,
  output logic       alusrca_o,
  output logic [1:0] alusrcb_o,
  output logic [1:0] aluop_o,
  output logic [1:0] pcsrc_o,
  output logic       illegal_o,
  output logic       err_o,
  output logic [3:0] state_o
);

  // state    | meaning
  // FETCH    | read instruction at PC, PC+4 on ready
  // DECODE   | register read, branch target into ALUOut
  // MEMADR   | effective address for lw/sw
  // MEMRD    | data read, waits on ready
  // MEMWB    | MDR -> rt
  // MEMWR    | data write, waits on ready
  // EXEC     | R-type ALU operation
  // RTYPEWB  | ALUOut -> rd
  // BEQ      | compare, branch if zero
  // JUMP     | load jump target
  // ADDIEX   | rs + imm
  // ADDIWB   | ALUOut -> rt
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQ     = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam bit             TO_EN   = (MEM_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic       pc_en, iord, memread, memwrite, irwrite;
  logic       regdst, memtoreg, regwrite, alusrca, illegal;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic       mem_wait, to_hit, timeout;

  assign to_hit = TO_EN && (cnt_q == TO_LAST) && !mem_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_en    = 1'b0;
    iord     = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    aluop    = 2'b00;
    pcsrc    = 2'b00;
    illegal  = 1'b0;
    mem_wait = 1'b0;
    case (state_q)
      S_FETCH: begin
        memread  = 1'b1;
        alusrcb  = 2'b01;
        mem_wait = 1'b1;
        if (mem_ready_i) begin
          irwrite = 1'b1;
          pc_en   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op_i == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        memread  = 1'b1;
        iord     = 1'b1;
        mem_wait = 1'b1;
        if (mem_ready_i)  state_d = S_MEMWB;
        else if (to_hit)  state_d = S_FETCH;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        mem_wait = 1'b1;
        if (mem_ready_i || to_hit) state_d = S_FETCH;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQ: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        pc_en   = zero_i;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Timeout only fires while still not ready, so a late ready always wins.
  assign timeout = mem_wait && to_hit;

  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) || timeout)
      cnt_d = '0;
    else if (mem_wait && !mem_ready_i && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  assign err_d = err_q | timeout;

  // Outputs are held low during reset even though FETCH would otherwise read.
  assign pc_en_o    = pc_en    & ~rst_i;
  assign iord_o     = iord     & ~rst_i;
  assign memread_o  = memread  & ~rst_i;
  assign memwrite_o = memwrite & ~rst_i;
  assign irwrite_o  = irwrite  & ~rst_i;
  assign regdst_o   = regdst   & ~rst_i;
  assign memtoreg_o = memtoreg & ~rst_i;
  assign regwrite_o = regwrite & ~rst_i;
  assign alusrca_o  = alusrca  & ~rst_i;
  assign illegal_o  = illegal  & ~rst_i;
  assign alusrcb_o  = rst_i ? 2'b00 : alusrcb;
  assign aluop_o    = rst_i ? 2'b00 : aluop;
  assign pcsrc_o    = rst_i ? 2'b00 : pcsrc;
  assign err_o      = err_q & ~rst_i;
  assign state_o    = rst_i ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (timeout shortened to 3 cycles).
// Control outputs are packed into one 16-bit word compared against hand-built constants.
module tb_multicycle_control;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [5:0] op_i;
  logic       zero_i;
  logic       mem_ready_i;
  logic       pc_en_o, iord_o, memread_o, memwrite_o, irwrite_o;
  logic       regdst_o, memtoreg_o, regwrite_o, alusrca_o, illegal_o, err_o;
  logic [1:0] alusrcb_o, aluop_o, pcsrc_o;
  logic [3:0] state_o;

  int n_total = 0;
  int n_bad   = 0;

  multicycle_control #(.MEM_TIMEOUT(3), .CNT_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .op_i(op_i), .zero_i(zero_i),
    .mem_ready_i(mem_ready_i), .pc_en_o(pc_en_o), .iord_o(iord_o),
    .memread_o(memread_o), .memwrite_o(memwrite_o), .irwrite_o(irwrite_o),
    .regdst_o(regdst_o), .memtoreg_o(memtoreg_o), .regwrite_o(regwrite_o),
    .alusrca_o(alusrca_o), .alusrcb_o(alusrcb_o), .aluop_o(aluop_o),
    .pcsrc_o(pcsrc_o), .illegal_o(illegal_o), .err_o(err_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  // {pc_en,iord,memread,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,aluop,pcsrc,illegal}
  logic [15:0] ctrl;
  assign ctrl = {pc_en_o, iord_o, memread_o, memwrite_o, irwrite_o, regdst_o,
                 memtoreg_o, regwrite_o, alusrca_o, alusrcb_o, aluop_o, pcsrc_o, illegal_o};

  localparam logic [15:0] C_FETCH_R  = 16'hA820;
  localparam logic [15:0] C_FETCH_W  = 16'h2020;
  localparam logic [15:0] C_DECODE   = 16'h0060;
  localparam logic [15:0] C_DEC_ILL  = 16'h0061;
  localparam logic [15:0] C_MEMADR   = 16'h00C0;
  localparam logic [15:0] C_MEMRD    = 16'h6000;
  localparam logic [15:0] C_MEMWB    = 16'h0300;
  localparam logic [15:0] C_MEMWR    = 16'h5000;
  localparam logic [15:0] C_EXEC     = 16'h0090;
  localparam logic [15:0] C_RTYPEWB  = 16'h0500;
  localparam logic [15:0] C_BEQ_T    = 16'h808A;
  localparam logic [15:0] C_BEQ_N    = 16'h008A;
  localparam logic [15:0] C_JUMP     = 16'h8004;
  localparam logic [15:0] C_ADDIEX   = 16'h00C0;
  localparam logic [15:0] C_ADDIWB   = 16'h0100;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: apply inputs, check state and control word, advance past the edge.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [15:0] ctl,
                     input logic rdy, input logic zr);
    mem_ready_i = rdy;
    zero_i      = zr;
    #1;
    check_val({tag, ".state"}, 32'(state_o), 32'(st));
    check_val({tag, ".ctrl"},  32'(ctrl),    32'(ctl));
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; op_i = 6'b0; zero_i = 1'b0; mem_ready_i = 1'b0;
    #2;
    check_val("rst.ctrl",  32'(ctrl),    32'h0);
    check_val("rst.state", 32'(state_o), 32'h0);
    check_val("rst.err",   32'(err_o),   32'h0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    op_i = 6'b000000;
    cyc("r.f", 0, C_FETCH_R, 1, 0);
    cyc("r.d", 1, C_DECODE,  1, 0);
    cyc("r.x", 6, C_EXEC,    1, 0);
    cyc("r.w", 7, C_RTYPEWB, 1, 0);

    op_i = 6'b100011;
    cyc("lw.f",  0, C_FETCH_R, 1, 0);
    cyc("lw.d",  1, C_DECODE,  1, 0);
    cyc("lw.a",  2, C_MEMADR,  1, 0);
    cyc("lw.r0", 3, C_MEMRD,   0, 0);
    cyc("lw.r1", 3, C_MEMRD,   0, 0);
    cyc("lw.r2", 3, C_MEMRD,   1, 0);
    cyc("lw.wb", 4, C_MEMWB,   1, 0);

    op_i = 6'b101011;
    cyc("sw.f", 0, C_FETCH_R, 1, 0);
    cyc("sw.d", 1, C_DECODE,  1, 0);
    cyc("sw.a", 2, C_MEMADR,  1, 0);
    cyc("sw.w", 5, C_MEMWR,   1, 0);

    op_i = 6'b000100;
    cyc("beq1.f", 0, C_FETCH_R, 1, 1);
    cyc("beq1.d", 1, C_DECODE,  1, 1);
    cyc("beq1.b", 8, C_BEQ_T,   1, 1);
    cyc("beq0.f", 0, C_FETCH_R, 1, 0);
    cyc("beq0.d", 1, C_DECODE,  1, 0);
    cyc("beq0.b", 8, C_BEQ_N,   1, 0);

    op_i = 6'b000010;
    cyc("j.f", 0, C_FETCH_R, 1, 0);
    cyc("j.d", 1, C_DECODE,  1, 0);
    cyc("j.j", 9, C_JUMP,    1, 0);

    op_i = 6'b001000;
    cyc("ai.f", 0,  C_FETCH_R, 1, 0);
    cyc("ai.d", 1,  C_DECODE,  1, 0);
    cyc("ai.x", 10, C_ADDIEX,  1, 0);
    cyc("ai.w", 11, C_ADDIWB,  1, 0);

    op_i = 6'b111111;
    cyc("ill.f", 0, C_FETCH_R, 1, 0);
    cyc("ill.d", 1, C_DEC_ILL, 1, 0);
    check_val("ill.err", 32'(err_o), 32'h0);

    // Ready arriving on the last tolerated cycle completes the fetch.
    op_i = 6'b000000;
    cyc("late.f0", 0, C_FETCH_W, 0, 0);
    cyc("late.f1", 0, C_FETCH_W, 0, 0);
    cyc("late.f2", 0, C_FETCH_R, 1, 0);
    cyc("late.d",  1, C_DECODE,  1, 0);
    check_val("late.err", 32'(err_o), 32'h0);
    cyc("late.x",  6, C_EXEC,    1, 0);
    cyc("late.w",  7, C_RTYPEWB, 1, 0);

    cyc("to.f0", 0, C_FETCH_W, 0, 0);
    cyc("to.f1", 0, C_FETCH_W, 0, 0);
    check_val("to.err_pre", 32'(err_o), 32'h0);
    cyc("to.f2", 0, C_FETCH_W, 0, 0);
    check_val("to.err", 32'(err_o), 32'h1);
    // Counter must restart: two more misses then ready still fetches.
    cyc("to.g0", 0, C_FETCH_W, 0, 0);
    cyc("to.g1", 0, C_FETCH_W, 0, 0);
    cyc("to.g2", 0, C_FETCH_R, 1, 0);
    cyc("to.d",  1, C_DECODE,  1, 0);
    check_val("to.sticky", 32'(err_o), 32'h1);
    cyc("to.x",  6, C_EXEC,    1, 0);
    cyc("to.w",  7, C_RTYPEWB, 1, 0);

    op_i = 6'b101011;
    cyc("rs.f", 0, C_FETCH_R, 1, 0);
    cyc("rs.d", 1, C_DECODE,  1, 0);
    cyc("rs.a", 2, C_MEMADR,  1, 0);
    mem_ready_i = 1'b0;
    #1;
    check_val("rs.memwr", 32'(ctrl), 32'(C_MEMWR));
    #1;
    rst_i = 1'b1;
    #1;
    check_val("rs.ctrl",  32'(ctrl),    32'h0);
    check_val("rs.state", 32'(state_o), 32'h0);
    check_val("rs.err",   32'(err_o),   32'h0);
    @(posedge clk_i);
    #3;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    check_val("rs.post_state", 32'(state_o), 32'h0);
    check_val("rs.post_ctrl",  32'(ctrl),    32'(C_FETCH_W));
    check_val("rs.post_err",   32'(err_o),   32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
